// File: rtl/vram_arbiter.sv
// Arbitrates a single-port VRAM between the FSX fetch engine (absolute priority)
// and single-cycle CPU requests, and records the worst-case CPU grant wait.
module vram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              vga_clk,
    input  logic              nreset,
    input  logic              fsx_active,
    input  logic [ADDR_W-1:0] fsx_addr,
    output logic [DATA_W-1:0] fsx_q,
    input  logic              cpu_start,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [15:0]       stall_max,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [15:0]       wait_cnt;
    logic              grant;

    // The CPU owns the RAM port only in a WAIT cycle the FSX leaves free.
    assign grant = (state == WAIT) && !fsx_active;
    assign fsx_q = ram_q;

    always_ff @(posedge vga_clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cpu_start) next_state = WAIT;
            WAIT:    if (grant) next_state = lat_we ? DONE : CAPTURE;
            CAPTURE: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!nreset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            wait_cnt  <= '0;
            stall_max <= '0;
            cpu_q     <= '0;
        end else begin
            if (state == IDLE && cpu_start) begin
                lat_we   <= cpu_we;
                lat_addr <= cpu_addr;
                lat_data <= cpu_data;
                wait_cnt <= '0;
            end
            if (state == WAIT && fsx_active && wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (grant && wait_cnt > stall_max) begin
                stall_max <= wait_cnt;
            end
            // RAM data for a granted read appears one cycle later, whoever owns the port now.
            if (state == CAPTURE) begin
                cpu_q <= ram_q;
            end
        end
    end

    // Reset also masks a pending grant so no write can slip out in the reset cycle.
    always_comb begin
        cpu_busy = (state != IDLE);
        cpu_done = (state == DONE);
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        if (fsx_active) begin
            ram_addr = fsx_addr;
        end else if (grant && nreset) begin
            ram_addr = lat_addr;
            ram_d    = lat_data;
            ram_we   = lat_we;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural 1-cycle registered VRAM.
module tb_vram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              vga_clk = 1'b0;
    logic              nreset;
    logic              fsx_active;
    logic [ADDR_W-1:0] fsx_addr;
    logic [DATA_W-1:0] fsx_q;
    logic              cpu_start;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] cpu_q;
    logic              cpu_busy;
    logic              cpu_done;
    logic [15:0]       stall_max;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checkCount = 0;
    int passCount  = 0;

    always #5 vga_clk = ~vga_clk;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .vga_clk   (vga_clk),
        .nreset    (nreset),
        .fsx_active(fsx_active),
        .fsx_addr  (fsx_addr),
        .fsx_q     (fsx_q),
        .cpu_start (cpu_start),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_q     (cpu_q),
        .cpu_busy  (cpu_busy),
        .cpu_done  (cpu_done),
        .stall_max (stall_max),
        .ram_addr  (ram_addr),
        .ram_d     (ram_d),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    // Read-first single-port RAM; the preload port lets the bench seed contents.
    always @(posedge vga_clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_d;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input logic fsx);
        cpu_start  = start;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_data   = data;
        fsx_active = fsx;
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        step();
        pre_en = 1'b0;
    endtask

    initial begin
        nreset   = 1'b0;
        fsx_addr = 11'h010;
        pre_en   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        preload(11'h400, 32'h11223344);
        preload(11'h200, 32'hCAFEF00D);
        preload(11'h7FF, 32'h0BADF00D);
        preload(11'h033, 32'h33333333);
        preload(11'h123, 32'h00000000);

        checkOutput("rst_busy", 32'(cpu_busy), 32'd0);
        checkOutput("rst_done", 32'(cpu_done), 32'd0);
        checkOutput("rst_q", cpu_q, 32'd0);
        checkOutput("rst_stall", 32'(stall_max), 32'd0);
        checkOutput("rst_we", 32'(ram_we), 32'd0);
        checkOutput("rst_addr", 32'(ram_addr), 32'd0);

        nreset = 1'b1;
        step();

        // Uncontended write: grant at cycle 1, done at cycle 2.
        applyStimulus(1'b1, 1'b1, 11'h123, 32'hDEADBEEF, 1'b0);
        checkOutput("wr_c0_busy", 32'(cpu_busy), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("wr_c1_we", 32'(ram_we), 32'd1);
        checkOutput("wr_c1_addr", 32'(ram_addr), 32'h123);
        checkOutput("wr_c1_d", ram_d, 32'hDEADBEEF);
        checkOutput("wr_c1_busy", 32'(cpu_busy), 32'd1);
        checkOutput("wr_c1_done", 32'(cpu_done), 32'd0);
        step();
        checkOutput("wr_c2_done", 32'(cpu_done), 32'd1);
        checkOutput("wr_c2_we", 32'(ram_we), 32'd0);
        checkOutput("wr_mem", mem[11'h123], 32'hDEADBEEF);
        step();
        checkOutput("wr_c3_done", 32'(cpu_done), 32'd0);
        checkOutput("wr_c3_busy", 32'(cpu_busy), 32'd0);
        checkOutput("wr_stall", 32'(stall_max), 32'd0);

        // Uncontended read: done at cycle 3 with the RAM word.
        applyStimulus(1'b1, 1'b0, 11'h400, 32'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("rd_c1_addr", 32'(ram_addr), 32'h400);
        checkOutput("rd_c1_we", 32'(ram_we), 32'd0);
        step();
        checkOutput("rd_c2_done", 32'(cpu_done), 32'd0);
        checkOutput("rd_c2_busy", 32'(cpu_busy), 32'd1);
        step();
        checkOutput("rd_c3_done", 32'(cpu_done), 32'd1);
        checkOutput("rd_c3_q", cpu_q, 32'h11223344);
        step();

        // Contention: FSX holds the port for five WAIT cycles.
        applyStimulus(1'b1, 1'b1, 11'h055, 32'h0000A5A5, 1'b1);
        step();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
            checkOutput($sformatf("ct_c%0d_we", i), 32'(ram_we), 32'd0);
            checkOutput($sformatf("ct_c%0d_addr", i), 32'(ram_addr), 32'h010);
            step();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("ct_grant_we", 32'(ram_we), 32'd1);
        checkOutput("ct_grant_addr", 32'(ram_addr), 32'h055);
        step();
        checkOutput("ct_done", 32'(cpu_done), 32'd1);
        checkOutput("ct_stall", 32'(stall_max), 32'd5);
        step();

        // Toggling FSX during a read; capture happens while FSX owns the port.
        applyStimulus(1'b1, 1'b0, 11'h200, 32'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("tg_c1_addr", 32'(ram_addr), 32'h010);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("tg_c2_addr", 32'(ram_addr), 32'h200);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("tg_c3_fsxq", fsx_q, 32'hCAFEF00D);
        checkOutput("tg_c3_done", 32'(cpu_done), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("tg_c4_done", 32'(cpu_done), 32'd1);
        checkOutput("tg_c4_q", cpu_q, 32'hCAFEF00D);
        checkOutput("tg_stall", 32'(stall_max), 32'd5);
        step();
        checkOutput("tg_q_hold", cpu_q, 32'hCAFEF00D);

        // A second cpu_start while busy must be ignored.
        applyStimulus(1'b1, 1'b1, 11'h0AA, 32'h00001111, 1'b1);
        step();
        applyStimulus(1'b1, 1'b1, 11'h7FF, 32'h00002222, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("ig_grant_addr", 32'(ram_addr), 32'h0AA);
        checkOutput("ig_grant_d", ram_d, 32'h00001111);
        step();
        checkOutput("ig_done", 32'(cpu_done), 32'd1);
        step();
        checkOutput("ig_done_once", 32'(cpu_done), 32'd0);
        checkOutput("ig_busy", 32'(cpu_busy), 32'd0);
        checkOutput("ig_mem7ff", mem[11'h7FF], 32'h0BADF00D);

        // Reset asserted while the write waits behind FSX.
        applyStimulus(1'b1, 1'b1, 11'h033, 32'h00009999, 1'b1);
        step();
        nreset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("rw_we_in_rst", 32'(ram_we), 32'd0);
        step();
        nreset = 1'b1;
        #1;
        checkOutput("rw_busy", 32'(cpu_busy), 32'd0);
        checkOutput("rw_done", 32'(cpu_done), 32'd0);
        checkOutput("rw_stall", 32'(stall_max), 32'd0);
        checkOutput("rw_q", cpu_q, 32'd0);
        checkOutput("rw_we", 32'(ram_we), 32'd0);
        checkOutput("rw_addr", 32'(ram_addr), 32'd0);
        step();
        checkOutput("rw_done_later", 32'(cpu_done), 32'd0);
        checkOutput("rw_mem033", mem[11'h033], 32'h33333333);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, VRAM word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, VRAM data width.
REQ-003 The block SHALL have port vga_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port fsx_active  input  1  FSX reads VRAM this cycle, absolute priority.
REQ-006 The block SHALL have port fsx_addr  input  ADDR_W  FSX read address.
REQ-007 The block SHALL have port fsx_q  output  DATA_W  FSX read data, wired directly to ram_q.
REQ-008 The block SHALL have port cpu_start  input  1  single-cycle CPU access request.
REQ-009 The block SHALL have port cpu_we  input  1  1 = write, 0 = read; sampled with cpu_start.
REQ-010 The block SHALL have port cpu_addr  input  ADDR_W  CPU address; sampled with cpu_start.
REQ-011 The block SHALL have port cpu_data  input  DATA_W  CPU write data; sampled with cpu_start.
REQ-012 The block SHALL have port cpu_q  output  DATA_W  registered CPU read data.
REQ-013 The block SHALL have port cpu_busy  output  1  request latched and not yet completed.
REQ-014 The block SHALL have port cpu_done  output  1  one-cycle completion pulse.
REQ-015 The block SHALL have port stall_max  output  16  largest grant wait seen since reset, saturating.
REQ-016 The block SHALL have ports ram_addr (output, ADDR_W), ram_d (output, DATA_W), ram_we (output, 1) and ram_q (input, DATA_W), connecting to a single-port VRAM with 1-cycle registered read.

Function
REQ-017 The block SHALL implement FSM states IDLE, WAIT, CAPTURE, DONE.
REQ-018 In IDLE with cpu_start=1, the block SHALL latch cpu_we, cpu_addr and cpu_data, clear the wait counter, and enter WAIT.
REQ-019 The block SHALL ignore cpu_start outside IDLE (no queueing, no corruption of latched request).
REQ-020 In WAIT with fsx_active=1, the block SHALL stay in WAIT and increment the 16-bit wait counter, saturating at 0xFFFF.
REQ-021 In WAIT with fsx_active=0, the block SHALL grant the CPU that cycle: ram_addr = latched address; ram_we = latched we; ram_d = latched data.
REQ-022 On a write grant the block SHALL go to DONE; on a read grant it SHALL go to CAPTURE.
REQ-023 In CAPTURE the block SHALL load cpu_q from ram_q regardless of fsx_active, then go to DONE.
REQ-024 In DONE the block SHALL drive cpu_done=1 for exactly one cycle and return to IDLE.
REQ-025 On leaving WAIT, stall_max SHALL update to max(stall_max, wait counter).
REQ-026 The block SHALL combine the RAM port combinationally: fsx_active=1 gives ram_addr=fsx_addr and ram_we=0, always, in every state.
REQ-027 When neither FSX nor a CPU grant is active, ram_addr SHALL be 0 and ram_we SHALL be 0.
REQ-028 ram_we SHALL never be 1 while fsx_active=1.
REQ-029 cpu_busy SHALL equal (state != IDLE).
REQ-030 cpu_q SHALL hold its value until the next completed read.
REQ-031 With no contention, latency from the cpu_start cycle to cpu_done SHALL be 2 cycles for a write and 3 cycles for a read.
REQ-032 fsx_active may toggle every cycle (the FSX 4-phase fetch is continuous in the active area); the grant SHALL occur on the first cycle with fsx_active=0.

Reset
REQ-033 With nreset=0 at a clock edge, the block SHALL enter IDLE and set cpu_q=0, cpu_done=0, cpu_busy=0, stall_max=0, the wait counter to 0 and the latched request to 0.
REQ-034 Reset mid-operation (WAIT or CAPTURE) SHALL abandon the request without a cpu_done pulse.
REQ-035 The block SHALL not issue any write after the reset edge.

Verification
REQ-036 Write with no contention: fsx_active=0, cpu_start with we=1, addr=0x123, data=0xDEADBEEF -> ram_we=1 with that addr/data at cycle 1, cpu_done at cycle 2, stall_max=0.
REQ-037 Read with no contention: RAM[0x400]=0x11223344, read request -> cpu_q=0x11223344 and cpu_done at cycle 3.
REQ-038 Contention: fsx_active=1 for 5 cycles after the request -> grant on the first idle cycle, ram_we never coincides with fsx_active, and stall_max=5.
REQ-039 Toggling fsx_active (1,0,1,0) during a read -> grant at the first 0, and cpu_q takes the RAM data even though fsx_active=1 in CAPTURE.
REQ-040 cpu_start pulsed while busy with addr=0x7FF -> ignored; the original address is used and only one cpu_done pulse occurs.
REQ-041 nreset=0 asserted during WAIT -> IDLE next cycle, no cpu_done, ram_we=0, and all outputs at their reset values.
